stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N:1 streaming multiplexer with round-robin arbitration, a valid/ready handshake per input and a registered output stage. It generalises the fixed 8:1 combinational select tree: the select is produced internally by a fair arbiter rather than supplied by the caller. It sits wherever several producers share one consumer, for example multiple requesters into a shared memory/bus port or writeback arbitration. Throughput is one beat per cycle; latency is one cycle.

## Interface
- `WIDTH`, default 32: data width per channel.
- `N`, default 8: channel count, ≥2, any integer (power of two not required).
- `SELW`, default `$clog2(N)`: width of the channel index; derived, never overridden.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_last`  in  N  per-channel end-of-packet marker.
- `in_ready`  out  N  per-channel ready; one-hot or zero.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  registered data of the granted channel.
- `out_sel`  out  SELW  index of the channel the beat came from.
- `out_last`  out  1  registered `in_last` of the granted channel.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- Load enable: `load = !out_valid || out_ready`.
- Arbiter: among channels with `in_valid=1`, grant the first at or after `ptr`, searching upward modulo N. `ptr` resets to 0, so channel 0 has priority first.
- `in_ready[g] = load && any_valid && grant==g`; all other bits are 0. `in_ready` must not depend on `out_valid` of the same cycle except through `load`.
- Transfer on channel g (`in_valid[g] && in_ready[g]`): `out_data<=in_data[g]`, `out_sel<=g`, `out_last<=in_last[g]`, `out_valid<=1`, `ptr<=(g==N-1)?0:g+1`.
- `load=1` with no valid input: `out_valid<=0`. Data, sel and last hold their old values.
- `out_valid=1 && out_ready=0`: all output registers hold; `in_ready` is all-zero.
- Reset: `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `ptr=0`, lock cleared. Reset mid-stream drops the held beat with no handshake on either side.

## Timing
- Latency: an input accepted in cycle t appears on `out_*` in cycle t+1.
- Full throughput: with `out_ready` held at 1, one beat is accepted every cycle.
- Fairness: with all N channels continuously valid, each channel is granted exactly once per N consecutive transfers.
- Simultaneous `out_ready` and a new grant in the same cycle: the old beat leaves and the new beat loads, with no bubble.
- Arbitration and `in_ready` are combinational from `in_valid`, `ptr`, the lock state, `out_valid` and `out_ready`. No combinational path exists from `in_data` to `out_data`.

## Configuration
- `STREAM_MUX_LAST_LOCK_EN` defined: packet lock.
  - Accepting a beat from channel g with `in_last=0` sets lock to g.
  - While locked, only g can be granted. If g is not valid, no channel is granted and a bubble results.
  - `ptr` advances only on the beat with `in_last=1`, which also clears the lock.
- Macro undefined: per-beat arbitration. `ptr` advances on every transfer; `in_last` is only carried through to `out_last`.

## Structure
- Package `stream_mux_pkg`: holds the `WIDTH`/`N` defaults and a `sel_t`-style index width helper function.
- Sub-module `rr_arbiter` (parameter `N`): takes the request vector, `ptr` and an optional lock; produces a one-hot grant and its index. `stream_mux_rr` owns the pointer, lock and output registers.

## Test plan
- Reset: assert `rst` mid-transfer with `out_valid=1` → next cycle `out_valid=0`, `out_sel=0`, `out_data=0`; first grant afterwards goes to channel 0 when all channels are valid.
- N=8, all valid, `out_ready=1`, channel i data=0x100+i → `out_sel` sequence 0,1,…,7,0; one beat per cycle.
- N=5, only channels 4 and 1 valid → grants 1,4,1,4. `ptr` wraps from 4 to 0.
- Backpressure: `out_ready=0` for 3 cycles while `out_valid=1` → `out_data` stable, `in_ready=0`; on release, the next beat loads in the same cycle.
- Sparse: only channel 3 valid, data 0xDEADBEEF, for one cycle → `out_valid=1` for exactly one cycle with `out_sel=3`.
- With `STREAM_MUX_LAST_LOCK_EN`: channel 2 sends 3 beats (last on the third) while channel 5 is valid throughout, and channel 2 drops valid for one cycle mid-packet → bubble, no grant to 5; channel 5 is granted only after the last beat. Without the macro → grants alternate 2,5,2.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared defaults and helpers for the round-robin stream multiplexer.
// Contents:
//   WIDTH_DEF, N_DEF : default data width and channel count
//   sel_width()      : width of a channel index for a given channel count
package stream_mux_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned N_DEF     = 8;

   // Index width for n channels; never below one bit
   function automatic int unsigned sel_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional lock override.
// Ports:
//   req_i      : request vector, one bit per channel
//   ptr_i      : highest-priority channel; search runs upward modulo N
//   lock_i     : when set, only lock_idx_i may be granted
//   lock_idx_i : channel held by the lock
//   gnt_o      : one-hot grant (all-zero when nothing is granted)
//   gnt_idx_o  : index of the granted channel (0 when nothing is granted)
//   gnt_any_o  : a grant was issued
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned SELW = sel_width(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [SELW-1:0] ptr_i,
   input  logic            lock_i,
   input  logic [SELW-1:0] lock_idx_i,
   output logic [N-1:0]    gnt_o,
   output logic [SELW-1:0] gnt_idx_o,
   output logic            gnt_any_o
);

   // First requester at or after ptr_i; locked channel only when locked
   always_comb begin
      int unsigned     idx;
      logic [SELW-1:0] idx_s;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      idx       = 0;
      idx_s     = '0;
      if (lock_i) begin
         if (req_i[lock_idx_i]) begin
            gnt_o[lock_idx_i] = 1'b1;
            gnt_idx_o         = lock_idx_i;
            gnt_any_o         = 1'b1;
         end
      end else begin
         for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) idx = idx - N;
            idx_s = SELW'(idx);
            if (!gnt_any_o && req_i[idx_s]) begin
               gnt_o[idx_s] = 1'b1;
               gnt_idx_o    = idx_s;
               gnt_any_o    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 streaming multiplexer with round-robin arbitration and a registered
// output stage (one-cycle latency, one beat per cycle).
// Optional feature: define STREAM_MUX_LAST_LOCK_EN to hold the grant on one
// channel until its in_last beat (packet lock). Undefined: per-beat arbitration.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : per-channel valid
//   in_data   : flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_last   : per-channel end-of-packet marker
//   in_ready  : per-channel ready, one-hot or zero
//   out_valid : output register holds a beat
//   out_data  : registered data of the granted channel
//   out_sel   : index of the channel the beat came from
//   out_last  : registered in_last of the granted channel
//   out_ready : consumer accepts the beat
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned N     = N_DEF,
   parameter int unsigned SELW  = sel_width(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               out_last,
   input  logic               out_ready
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_sel_q,   out_sel_d;
   logic             out_last_q,  out_last_d;
   logic [SELW-1:0]  ptr_q,       ptr_d;

   logic             load_c;
   logic [N-1:0]     gnt_c;
   logic [SELW-1:0]  gnt_idx_c;
   logic             gnt_any_c;
   logic [WIDTH-1:0] sel_data_c;
   logic             sel_last_c;
   logic [SELW-1:0]  ptr_nxt_c;
   logic             lock_c;
   logic [SELW-1:0]  lock_idx_c;

`ifdef STREAM_MUX_LAST_LOCK_EN
   logic             lock_q,     lock_d;
   logic [SELW-1:0]  lock_idx_q, lock_idx_d;
   assign lock_c     = lock_q;
   assign lock_idx_c = lock_idx_q;
`else
   assign lock_c     = 1'b0;
   assign lock_idx_c = '0;
`endif

   // Output register may take a new beat when empty or being drained
   assign load_c = !out_valid_q || out_ready;

   rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req_i      (in_valid),
      .ptr_i      (ptr_q),
      .lock_i     (lock_c),
      .lock_idx_i (lock_idx_c),
      .gnt_o      (gnt_c),
      .gnt_idx_o  (gnt_idx_c),
      .gnt_any_o  (gnt_any_c)
   );

   assign in_ready = (load_c && gnt_any_c) ? gnt_c : '0;

   // Payload of the granted channel
   always_comb begin
      sel_data_c = '0;
      sel_last_c = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt_idx_c == SELW'(i)) begin
            sel_data_c = in_data[i*WIDTH +: WIDTH];
            sel_last_c = in_last[i];
         end
      end
   end

   assign ptr_nxt_c = (gnt_idx_c == SELW'(N-1)) ? '0 : gnt_idx_c + SELW'(1);

   // Next-state: load on transfer, drain to empty when nothing is granted
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_last_d  = out_last_q;
      ptr_d       = ptr_q;
`ifdef STREAM_MUX_LAST_LOCK_EN
      lock_d      = lock_q;
      lock_idx_d  = lock_idx_q;
`endif
      if (load_c) begin
         if (gnt_any_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_sel_d   = gnt_idx_c;
            out_last_d  = sel_last_c;
`ifdef STREAM_MUX_LAST_LOCK_EN
            // Pointer moves only at packet end; mid-packet beats lock the channel
            if (sel_last_c) begin
               ptr_d  = ptr_nxt_c;
               lock_d = 1'b0;
            end else begin
               lock_d     = 1'b1;
               lock_idx_d = gnt_idx_c;
            end
`else
            ptr_d = ptr_nxt_c;
`endif
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_last_q  <= 1'b0;
         ptr_q       <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_last_q  <= out_last_d;
         ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LAST_LOCK_EN
         lock_q      <= lock_d;
         lock_idx_q  <= lock_idx_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel and a 5-channel instance
// sharing clock and reset. Expected values are hand-derived per scenario.
module tb_stream_mux_rr;

   logic           clk = 1'b0;
   logic           rst = 1'b1;

   logic [7:0]     v8    = '0;
   logic [8*32-1:0] d8   = '0;
   logic [7:0]     l8    = '0;
   logic [7:0]     rdy8;
   logic           ov8;
   logic [31:0]    od8;
   logic [2:0]     os8;
   logic           ol8;
   logic           ordy8 = 1'b0;

   logic [4:0]     v5    = '0;
   logic [5*32-1:0] d5   = '0;
   logic [4:0]     l5    = '0;
   logic [4:0]     rdy5;
   logic           ov5;
   logic [31:0]    od5;
   logic [2:0]     os5;
   logic           ol5;
   logic           ordy5 = 1'b0;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(32), .N(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_last(l8),
      .in_ready(rdy8), .out_valid(ov8), .out_data(od8), .out_sel(os8),
      .out_last(ol8), .out_ready(ordy8)
   );

   stream_mux_rr #(.WIDTH(32), .N(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_last(l5),
      .in_ready(rdy5), .out_valid(ov5), .out_data(od5), .out_sel(os5),
      .out_last(ol5), .out_ready(ordy5)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_data();
      for (int i = 0; i < 8; i++) d8[i*32 +: 32] = 32'h100 + 32'(i);
      for (int i = 0; i < 5; i++) d5[i*32 +: 32] = 32'h200 + 32'(i);
   endtask

   task automatic do_reset();
      rst = 1'b1; v8 = '0; v5 = '0; l8 = '0; l5 = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; v8 = '0; ordy8 = 1'b0;
      step(); step();
      checks++; if (ov8 !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", ov8); else passes++;
      checks++; if (od8 !== 32'h0) $display("FAIL reset_data: got %0h expected 0", od8); else passes++;
      checks++; if (os8 !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", os8); else passes++;
      checks++; if (ol8 !== 1'b0) $display("FAIL reset_last: got %0h expected 0", ol8); else passes++;
      // Load one beat and leave it stalled
      rst = 1'b0; fill_data(); v8 = 8'hFF; ordy8 = 1'b0;
      #1;
      checks++; if (rdy8 !== 8'h01) $display("FAIL reset_first_ready: got %0h expected 01", rdy8); else passes++;
      step();
      checks++; if (ov8 !== 1'b1 || od8 !== 32'h100) $display("FAIL reset_preload: got v=%0h d=%0h expected v=1 d=100", ov8, od8); else passes++;
      // Reset mid-stream drops the held beat
      rst = 1'b1;
      step();
      checks++; if (ov8 !== 1'b0 || os8 !== 3'd0 || od8 !== 32'h0) $display("FAIL reset_midstream: got v=%0h s=%0d d=%0h expected 0 0 0", ov8, os8, od8); else passes++;
      rst = 1'b0; ordy8 = 1'b1;
      step();
      checks++; if (ov8 !== 1'b1 || os8 !== 3'd0) $display("FAIL reset_first_grant: got v=%0h s=%0d expected v=1 s=0", ov8, os8); else passes++;
      v8 = '0;
      step();
      checks++; if (ov8 !== 1'b0) $display("FAIL reset_drain: got %0h expected 0", ov8); else passes++;
   endtask

   task automatic test_rr_sequence();
      do_reset();
      fill_data(); v8 = 8'hFF; ordy8 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         checks++;
         if (ov8 !== 1'b1 || os8 !== 3'(k % 8) || od8 !== 32'h100 + 32'(k % 8))
            $display("FAIL rr_seq_%0d: got v=%0h s=%0d d=%0h expected v=1 s=%0d d=%0h",
                     k, ov8, os8, od8, k % 8, 32'h100 + 32'(k % 8));
         else passes++;
      end
      v8 = '0;
      step();
   endtask

   task automatic test_two_channels();
      int exp_sel [4] = '{1, 4, 1, 4};
      do_reset();
      fill_data(); v5 = 5'b10010; ordy5 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (ov5 !== 1'b1 || os5 !== 3'(exp_sel[k]) || od5 !== 32'h200 + 32'(exp_sel[k]))
            $display("FAIL n5_grant_%0d: got v=%0h s=%0d d=%0h expected v=1 s=%0d d=%0h",
                     k, ov5, os5, od5, exp_sel[k], 32'h200 + 32'(exp_sel[k]));
         else passes++;
      end
      v5 = '0;
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      fill_data(); v8 = 8'hFF; ordy8 = 1'b1;
      step();
      checks++; if (os8 !== 3'd0 || ov8 !== 1'b1) $display("FAIL bp_first: got v=%0h s=%0d expected v=1 s=0", ov8, os8); else passes++;
      ordy8 = 1'b0;
      #1;
      checks++; if (rdy8 !== 8'h00) $display("FAIL bp_ready_low: got %0h expected 00", rdy8); else passes++;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (ov8 !== 1'b1 || os8 !== 3'd0 || od8 !== 32'h100 || rdy8 !== 8'h00)
            $display("FAIL bp_hold_%0d: got v=%0h s=%0d d=%0h rdy=%0h expected v=1 s=0 d=100 rdy=00",
                     k, ov8, os8, od8, rdy8);
         else passes++;
      end
      ordy8 = 1'b1;
      #1;
      checks++; if (rdy8 !== 8'h02) $display("FAIL bp_release_ready: got %0h expected 02", rdy8); else passes++;
      step();
      checks++; if (ov8 !== 1'b1 || os8 !== 3'd1 || od8 !== 32'h101) $display("FAIL bp_release_load: got v=%0h s=%0d d=%0h expected v=1 s=1 d=101", ov8, os8, od8); else passes++;
      v8 = '0;
      step();
   endtask

   task automatic test_sparse();
      do_reset();
      fill_data(); d8[3*32 +: 32] = 32'hDEADBEEF; ordy8 = 1'b1;
      v8 = 8'h08;
      step();
      v8 = '0;
      checks++; if (ov8 !== 1'b1 || os8 !== 3'd3 || od8 !== 32'hDEADBEEF) $display("FAIL sparse_beat: got v=%0h s=%0d d=%0h expected v=1 s=3 d=deadbeef", ov8, os8, od8); else passes++;
      step();
      checks++; if (ov8 !== 1'b0) $display("FAIL sparse_one_cycle: got %0h expected 0", ov8); else passes++;
      step();
      checks++; if (ov8 !== 1'b0) $display("FAIL sparse_idle: got %0h expected 0", ov8); else passes++;
   endtask

   task automatic test_lock();
      logic [7:0] vin  [5] = '{8'h24, 8'h20, 8'h24, 8'h24, 8'h20};
      logic [7:0] lin  [5] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
`ifdef STREAM_MUX_LAST_LOCK_EN
      logic       ev   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int         es   [5] = '{2, 0, 2, 2, 5};
      logic       el_d     = 1'b1;
      logic [7:0] rdy_b    = 8'h00;
`else
      logic       ev   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      int         es   [5] = '{2, 5, 2, 5, 5};
      logic       el_d     = 1'b0;
      logic [7:0] rdy_b    = 8'h20;
`endif
      do_reset();
      fill_data(); ordy8 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         v8 = vin[k]; l8 = lin[k];
         if (k == 1) begin
            #1;
            checks++; if (rdy8 !== rdy_b) $display("FAIL lock_ready_gap: got %0h expected %0h", rdy8, rdy_b); else passes++;
         end
         step();
         checks++;
         if (ov8 !== ev[k] || (ev[k] && os8 !== 3'(es[k])))
            $display("FAIL lock_beat_%0d: got v=%0h s=%0d expected v=%0h s=%0d", k, ov8, os8, ev[k], es[k]);
         else passes++;
         if (k == 3) begin
            checks++; if (ol8 !== el_d) $display("FAIL lock_last: got %0h expected %0h", ol8, el_d); else passes++;
         end
      end
      v8 = '0; l8 = '0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_rr_sequence();
      test_two_channels();
      test_backpressure();
      test_sparse();
      test_lock();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
